interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Synchronous vectored interrupt controller for the Z80 side of the CPC2 FPGA.
//  Latches peripheral request edges into a pending register and applies a mask and priority.
//  Drives n_int_o and answers the Z80 mode-2 acknowledge cycle (M1+IORQ) with a vector byte.
//  Software manages it via a 4-register bus window; in-service tracking gives nesting by priority.
// PARAMETERS
//  NUM_IRQ      8   number of request lines, 2..8; bit 0 = irq_i[0]
//  SYNC_STAGES  2   synchroniser depth on irq_i, >=2
// PORTS
//  clk_i     in   1        system clock; single clock domain
//  rst_i     in   1        reset, asynchronous, active-high
//  irq_i     in   NUM_IRQ  peripheral requests, async, rising edge = request
//  sel_i     in   1        register window select, 1-cycle strobe
//  we_i      in   1        1 = write, 0 = read (valid with sel_i)
//  adr_i     in   2        register address
//  dat_i     in   8        write data
//  dat_o     out  8        read data, registered, valid the cycle after sel_i
//  n_m1_i    in   1        Z80 /M1, sampled on clk_i
//  n_iorq_i  in   1        Z80 /IORQ, sampled on clk_i
//  n_int_o   out  1        Z80 /INT, active-low, registered
//  vec_o     out  8        mode-2 vector byte
//  vec_oe_o  out  1        1 = drive vec_o onto the Z80 data bus
// BEHAVIOUR
//  Reset: pending=0, mask=8'hFF (all masked), base=8'h00, in-service=0, state IDLE,
//   n_int_o=1, vec_o=0, vec_oe_o=0, dat_o=0, synchronisers=0.
//  Registers: 0 PEND  (R; W1C), 1 MASK (RW, 1 = masked), 2 BASE (RW, bits[3:0] read 0),
//   3 ISR (R; any write = EOI, clears highest-priority set in-service bit).
//   Bits >= NUM_IRQ read 0 and ignore writes.
//  Edge capture: the rising edge of synchronised irq_i sets pend[i].
//   Set has priority over a same-cycle W1C. A held-high level does not re-set the bit.
//  Eligible: req = pend & ~mask. The winner is the highest-priority req bit.
//   It is eligible only if its priority is strictly above every set ISR bit.
//  Ack: ack = !n_m1_i & !n_iorq_i, sampled; ack_rise = ack & !ack_d.
//  FSM:
//   IDLE -> REQ   when eligible; n_int_o=0 from the next edge.
//   REQ  -> ACK   on ack_rise: latch idx, clear pend[idx], set isr[idx], n_int_o=1,
//                 vec_o={base[7:4],idx[2:0],1'b0}, vec_oe_o=1.
//   REQ  -> IDLE  if eligibility is lost (masked/cleared); n_int_o=1, no vector.
//   ACK  -> IDLE  when ack drops; vec_oe_o=0 the same edge.
//  Ack while IDLE (spurious): vec_o={base[7:4],4'hF}, vec_oe_o=1 while ack holds,
//   no pend/isr change.
//  Latency: irq_i rise before edge k -> pend set at edge k+SYNC_STAGES -> n_int_o low
//   at edge k+SYNC_STAGES+1.
//  Simultaneous: ack_rise and a register write in the same cycle -> the ack update applies
//   first, then the write. A W1C of pend[idx] is redundant. EOI clears the pre-ack ISR.
//  Async reset mid-ACK: outputs return to reset values immediately.
// CONFIGURATION
//  INTC_ROTATE_EN defined: rotating priority.
//   After an ack of idx, idx becomes lowest priority; the pointer resets to bit 0 highest.
//   ISR comparisons use the same rotated order.
//  Undefined: fixed priority, bit 0 highest; no pointer register.
// STRUCTURE
//  intc_defs.vh: register address localparams (INTC_PEND/MASK/BASE/ISR), FSM state
//   encodings, spurious nibble 4'hF.
//  Sub-module intc_prio_enc: combinational find-first with rotation input
//   (tied to 0 without INTC_ROTATE_EN); returns valid+idx. It is instantiated twice,
//   once for req and once for ISR.
// TESTING
//  1 Reset, MASK=0, BASE=8'h40, pulse irq_i[3] -> n_int_o low after SYNC_STAGES+1 edges;
//    ack -> vec_o=8'h46, vec_oe_o=1, PEND=0, ISR=8'h08.
//  2 irq_i[5] and irq_i[1] together, fixed priority -> first vector 8'h42;
//    no INT for 5 until EOI; after EOI, INT then 8'h4A.
//  3 Pending irq 2 with MASK bit 2 set while in REQ -> n_int_o high next edge, no vector;
//    unmask -> reasserts.
//  4 Ack with nothing pending -> vec_o=8'h4F, PEND/ISR unchanged.
//  5 W1C PEND bit 4 in the same cycle as the irq_i[4] edge -> PEND bit 4 stays 1.
//  6 INTC_ROTATE_EN: irq 0 and 1 pending, ack 0, EOI, re-raise 0 -> next vector serves 1 (8'h42).

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants, FSM encoding and priority-rank helper for the Z80 vectored interrupt controller.
package interrupt_controller_pkg;

  localparam logic [1:0] INTC_PEND = 2'd0;
  localparam logic [1:0] INTC_MASK = 2'd1;
  localparam logic [1:0] INTC_BASE = 2'd2;
  localparam logic [1:0] INTC_ISR  = 2'd3;

  // Low nibble of the vector returned for an acknowledge with nothing to serve.
  localparam logic [3:0] SPUR_NIB  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Rank 0 is the highest priority; ptr names the line currently holding rank 0.
  function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] ptr,
                                           input int n);
    int r;
    r = (int'(idx) - int'(ptr) + n) % n;
    return 3'(r);
  endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Combinational find-first: returns the set bit with the lowest rank relative to rot_i.
module intc_prio_enc
  import interrupt_controller_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] vec_i,
  input  logic [2:0]   rot_i,
  output logic         valid_o,
  output logic [2:0]   idx_o
);

  int best;

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    best    = N;
    for (int j = 0; j < N; j++) begin
      if (vec_i[j] && (int'(prio_rank(3'(j), rot_i, N)) < best)) begin
        best  = int'(prio_rank(3'(j), rot_i, N));
        idx_o = 3'(j);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Z80 mode-2 vectored interrupt controller: edge capture, mask, priority, in-service nesting.
// Define INTC_ROTATE_EN for rotating priority; otherwise fixed priority with bit 0 highest.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               sel_i,
  input  logic               we_i,
  input  logic [1:0]         adr_i,
  input  logic [7:0]         dat_i,
  output logic [7:0]         dat_o,
  input  logic               n_m1_i,
  input  logic               n_iorq_i,
  output logic               n_int_o,
  output logic [7:0]         vec_o,
  output logic               vec_oe_o
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, isr_q, isr_d;
  logic [3:0]         base_q, base_d;
  state_e             state_q, state_d;
  logic               ack_prev_q, ack_prev_d;
  logic               n_int_q, n_int_d, vec_oe_q, vec_oe_d;
  logic [7:0]         vec_q, vec_d, dat_q, dat_d;

  logic [NUM_IRQ-1:0] req, edges, ack_oh, eoi_oh;
  logic [2:0]         ptr, req_idx, isr_idx;
  logic               req_vld, isr_vld, eligible, ack, ack_rise, do_ack, wr, rd;

`ifdef INTC_ROTATE_EN
  logic [2:0] ptr_q, ptr_d;

  // The line just acknowledged drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (do_ack) ptr_d = (int'(req_idx) == NUM_IRQ - 1) ? 3'd0 : req_idx + 3'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 3'd0;
`endif

  assign req      = pend_q & ~mask_q;
  assign edges    = sync_q[SYNC_STAGES-1] & ~irq_prev_q;
  assign ack      = !n_m1_i && !n_iorq_i;
  assign ack_rise = ack && !ack_prev_q;
  assign wr       = sel_i && we_i;
  assign rd       = sel_i && !we_i;
  assign ack_oh   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << req_idx;
  assign eoi_oh   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << isr_idx;

  intc_prio_enc #(.N(NUM_IRQ)) u_req_enc (
    .vec_i(req), .rot_i(ptr), .valid_o(req_vld), .idx_o(req_idx)
  );

  intc_prio_enc #(.N(NUM_IRQ)) u_isr_enc (
    .vec_i(isr_q), .rot_i(ptr), .valid_o(isr_vld), .idx_o(isr_idx)
  );

  // A request may only preempt when it outranks everything already in service.
  assign eligible = req_vld &&
    (!isr_vld || (prio_rank(req_idx, ptr, NUM_IRQ) < prio_rank(isr_idx, ptr, NUM_IRQ)));

  always_comb begin
    sync_d[0] = irq_i;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    irq_prev_d = sync_q[SYNC_STAGES-1];
    ack_prev_d = ack;
  end

  always_comb begin
    state_d  = state_q;
    do_ack   = 1'b0;
    vec_d    = vec_q;
    vec_oe_d = 1'b0;
    pend_d   = pend_q;
    mask_d   = mask_q;
    base_d   = base_q;
    isr_d    = isr_q;
    dat_d    = dat_q;

    case (state_q)
      ST_IDLE: if (eligible) state_d = ST_REQ;
      ST_REQ: begin
        if (eligible && ack_rise) begin
          state_d = ST_ACK;
          do_ack  = 1'b1;
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  if (!ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    n_int_d = (state_d != ST_REQ);

    if (do_ack) begin
      vec_d    = {base_q, req_idx, 1'b0};
      vec_oe_d = 1'b1;
    end else if (state_d == ST_ACK) begin
      vec_oe_d = 1'b1;
    end else if (state_d == ST_IDLE && ack) begin
      vec_d    = {base_q, SPUR_NIB};
      vec_oe_d = 1'b1;
    end

    // Acknowledge bookkeeping lands first; the bus write then applies on top.
    if (do_ack) pend_d = pend_d & ~ack_oh;
    if (wr && adr_i == INTC_PEND) pend_d = pend_d & ~dat_i[NUM_IRQ-1:0];
    pend_d = pend_d | edges;

    if (wr && adr_i == INTC_ISR && isr_vld) isr_d = isr_d & ~eoi_oh;
    if (do_ack) isr_d = isr_d | ack_oh;

    if (wr && adr_i == INTC_MASK) mask_d = dat_i[NUM_IRQ-1:0];
    if (wr && adr_i == INTC_BASE) base_d = dat_i[7:4];

    if (rd) begin
      case (adr_i)
        INTC_PEND: dat_d = 8'(pend_q);
        INTC_MASK: dat_d = 8'(mask_q);
        INTC_BASE: dat_d = {base_q, 4'h0};
        default:   dat_d = 8'(isr_q);
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '1;
      base_q     <= '0;
      isr_q      <= '0;
      state_q    <= ST_IDLE;
      ack_prev_q <= 1'b0;
      n_int_q    <= 1'b1;
      vec_q      <= '0;
      vec_oe_q   <= 1'b0;
      dat_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      irq_prev_q <= irq_prev_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      base_q     <= base_d;
      isr_q      <= isr_d;
      state_q    <= state_d;
      ack_prev_q <= ack_prev_d;
      n_int_q    <= n_int_d;
      vec_q      <= vec_d;
      vec_oe_q   <= vec_oe_d;
      dat_q      <= dat_d;
    end
  end

  assign n_int_o  = n_int_q;
  assign vec_o    = vec_q;
  assign vec_oe_o = vec_oe_q;
  assign dat_o    = dat_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: stimulus queues expected read data and vectors, a monitor pops and compares.
module tb_interrupt_controller;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] irq = '0, dat = '0;
  logic       sel = 1'b0, we = 1'b0, n_m1 = 1'b1, n_iorq = 1'b1;
  logic [1:0] adr = '0;
  logic [7:0] dat_o, vec;
  logic       n_int, vec_oe;

  int n_chk = 0, n_fail = 0;
  logic [7:0] rd_exp_q[$], vec_exp_q[$];
  string      rd_nm_q[$];
  logic       rd_seen = 1'b0, oe_prev = 1'b0;

  interrupt_controller #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq), .sel_i(sel), .we_i(we), .adr_i(adr),
    .dat_i(dat), .dat_o(dat_o), .n_m1_i(n_m1), .n_iorq_i(n_iorq), .n_int_o(n_int),
    .vec_o(vec), .vec_oe_o(vec_oe)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(string nm, logic [7:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %02h with nothing expected", nm, act);
  endfunction

  always @(posedge clk) rd_seen <= sel & ~we;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_exp_q.size() == 0) unexpected("rd_unexpected", dat_o);
      else chk(rd_nm_q.pop_front(), dat_o, rd_exp_q.pop_front());
    end
    if (vec_oe && !oe_prev) begin
      if (vec_exp_q.size() == 0) unexpected("vec_unexpected", vec);
      else chk("vec", vec, vec_exp_q.pop_front());
    end
    oe_prev <= vec_oe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; we = 1'b1; adr = a; dat = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    rd_exp_q.push_back(e);
    rd_nm_q.push_back(nm);
    sel = 1'b1; we = 1'b0; adr = a;
    tick();
    sel = 1'b0;
  endtask

  task automatic do_ack(input logic [7:0] e);
    vec_exp_q.push_back(e);
    n_m1 = 1'b0; n_iorq = 1'b0;
    repeat (3) tick();
    n_m1 = 1'b1; n_iorq = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_int(input string nm);
    int n = 0;
    while (n_int !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 8'(n_int), 8'h00);
  endtask

  task automatic rst_dut();
    rst = 1'b1; irq = '0; n_m1 = 1'b1; n_iorq = 1'b1; sel = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    reg_wr(2'd1, 8'h00);
    reg_wr(2'd2, 8'h40);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_n_int", 8'(n_int), 8'h01);
    chk("rst_vec_oe", 8'(vec_oe), 8'h00);
    chk("rst_vec", vec, 8'h00);
    chk("rst_dat", dat_o, 8'h00);
    reg_rd(2'd0, 8'h00, "rst_pend");
    reg_rd(2'd1, 8'hFF, "rst_mask");
    reg_rd(2'd2, 8'h00, "rst_base");
    reg_rd(2'd3, 8'h00, "rst_isr");

    // Test 1: latency and basic acknowledge
    reg_wr(2'd1, 8'h00);
    reg_wr(2'd2, 8'h4C);
    reg_rd(2'd2, 8'h40, "base_low_zero");
    irq = 8'h08;
    tick(); chk("lat_e1", 8'(n_int), 8'h01);
    tick(); chk("lat_e2", 8'(n_int), 8'h01);
    tick(); chk("lat_e3", 8'(n_int), 8'h01);
    tick(); chk("lat_e4", 8'(n_int), 8'h00);
    reg_rd(2'd0, 8'h08, "t1_pend");
    do_ack(8'h46);
    chk("t1_int_released", 8'(n_int), 8'h01);
    reg_rd(2'd0, 8'h00, "t1_pend_clr");
    reg_rd(2'd3, 8'h08, "t1_isr");
    reg_wr(2'd3, 8'h00);
    reg_rd(2'd3, 8'h00, "t1_eoi");
    irq = 8'h00;

`ifndef INTC_ROTATE_EN
    // Test 2: fixed priority and nesting
    rst_dut();
    irq = 8'h22;
    wait_int("t2_int");
    do_ack(8'h42);
    reg_rd(2'd0, 8'h20, "t2_pend");
    reg_rd(2'd3, 8'h02, "t2_isr");
    repeat (3) tick();
    chk("t2_blocked", 8'(n_int), 8'h01);
    reg_wr(2'd3, 8'h00);
    wait_int("t2_int5");
    do_ack(8'h4A);
    reg_rd(2'd3, 8'h20, "t2_isr5");
    irq = 8'h26;
    wait_int("t2_nest_int");
    do_ack(8'h44);
    reg_rd(2'd3, 8'h24, "t2_isr_nest");
    reg_wr(2'd3, 8'h00);
    reg_rd(2'd3, 8'h20, "t2_eoi_high");
    reg_wr(2'd3, 8'h00);
    reg_rd(2'd3, 8'h00, "t2_eoi_all");
    irq = 8'h00;
`endif

    // Test 3: mask while requesting
    rst_dut();
    irq = 8'h04;
    wait_int("t3_int");
    reg_wr(2'd1, 8'h04);
    chk("t3_still_req", 8'(n_int), 8'h00);
    tick();
    chk("t3_deassert", 8'(n_int), 8'h01);
    repeat (3) tick();
    chk("t3_held_off", 8'(n_int), 8'h01);
    reg_rd(2'd0, 8'h04, "t3_pend");
    reg_wr(2'd1, 8'h00);
    tick();
    chk("t3_reassert", 8'(n_int), 8'h00);
    do_ack(8'h44);
    reg_rd(2'd0, 8'h00, "t3_pend_clr");
    reg_wr(2'd3, 8'h00);
    irq = 8'h00;

    // Test 4: spurious acknowledge
    do_ack(8'h4F);
    reg_rd(2'd0, 8'h00, "t4_pend");
    reg_rd(2'd3, 8'h00, "t4_isr");
    chk("t4_n_int", 8'(n_int), 8'h01);

    // Asynchronous reset in the middle of an acknowledge
    irq = 8'h08;
    wait_int("rst_mid_int");
    vec_exp_q.push_back(8'h46);
    n_m1 = 1'b0; n_iorq = 1'b0;
    repeat (2) tick();
    chk("mid_vec_oe_on", 8'(vec_oe), 8'h01);
    rst = 1'b1;
    #1;
    chk("mid_vec_oe", 8'(vec_oe), 8'h00);
    chk("mid_vec", vec, 8'h00);
    chk("mid_n_int", 8'(n_int), 8'h01);
    n_m1 = 1'b1; n_iorq = 1'b1;

    // Test 5: set beats same-cycle W1C; held level does not re-set
    rst_dut();
    reg_wr(2'd1, 8'h10);
    irq = 8'h10;
    tick();
    tick();
    reg_wr(2'd0, 8'h10);
    reg_rd(2'd0, 8'h10, "t5_set_wins");
    chk("t5_masked_no_int", 8'(n_int), 8'h01);
    reg_wr(2'd0, 8'h10);
    reg_rd(2'd0, 8'h00, "t5_level_no_reset");
    irq = 8'h00;

    // Test 6: priority after serving line 0 with line 1 still pending
    rst_dut();
    irq = 8'h03;
    wait_int("t6_int");
    do_ack(8'h40);
    reg_wr(2'd1, 8'hFF);
    reg_wr(2'd3, 8'h00);
    irq = 8'h02;
    tick();
    irq = 8'h03;
    repeat (4) tick();
    reg_rd(2'd0, 8'h03, "t6_pend");
    reg_wr(2'd1, 8'h00);
    wait_int("t6_int2");
`ifdef INTC_ROTATE_EN
    do_ack(8'h42);
    reg_rd(2'd3, 8'h02, "t6_isr");
`else
    do_ack(8'h40);
    reg_rd(2'd3, 8'h01, "t6_isr");
`endif
    reg_wr(2'd3, 8'h00);
    irq = 8'h00;

    repeat (3) tick();
    chk("rd_drained", 8'(rd_exp_q.size()), 8'h00);
    chk("vec_drained", 8'(vec_exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
